// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one req/ack bus access per M-stage memory
// instruction, stalls the pipeline while it is outstanding, and registers the W bundle.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PCSrcM,
  input  logic                RegWriteM,
  input  logic                MemtoRegM,
  input  logic                MemWriteM,
  input  logic [3:0]          RdM,
  input  logic [31:0]         ALUResultM,
  input  logic [31:0]         WriteDataM,
  input  logic [1:0]          Instr27_26M,
  input  logic [1:0]          Instr6_5M,
  input  logic [3:0]          byteEnableM,
  mem_stage_lsu_if.master     bus,
  output logic                StallM,
  output logic                PCSrcW,
  output logic                RegWriteW,
  output logic                MemtoRegW,
  output logic [3:0]          RdW,
  output logic [31:0]         ALUOutW,
  output logic [31:0]         ReadDataW,
  output logic                mem_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        access, is_word, is_half, ld_signed, misaligned;
  logic        start, done, tmo, squash;
  logic [31:0] wdata_st;
  logic [3:0]  be_st;

  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] lane,
                                               input logic word, input logic half,
                                               input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rd[{lane, 3'b000} +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    if (word)      r = rd;
    else if (half) r = sgn ? 32'(h) : {16'b0, h};
    else           r = sgn ? 32'(b) : {24'b0, b};
    return r;
  endfunction

  // Transfer size decode and store lane steering
  always_comb begin
    access     = MemtoRegM | MemWriteM;
    is_word    = (Instr27_26M == 2'b01) && (byteEnableM == 4'hF);
    is_half    = (Instr27_26M == 2'b00) && Instr6_5M[0];
    ld_signed  = (Instr27_26M == 2'b00) && Instr6_5M[1];
    misaligned = (is_half & ALUResultM[0]) | (is_word & (|ALUResultM[1:0]));
    wdata_st   = {4{WriteDataM[7:0]}};
    be_st      = byteEnableM;
    if (is_word) begin
      wdata_st = WriteDataM;
      be_st    = 4'hF;
    end else if (is_half) begin
      wdata_st = {2{WriteDataM[15:0]}};
      be_st    = ALUResultM[1] ? 4'b1100 : 4'b0011;
    end
    if (!MemWriteM) be_st = 4'hF;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    squash  = 1'b0;
    StallM  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misaligned) begin
            squash = 1'b1;
          end else begin
            start   = 1'b1;
            StallM  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // An ack in the final timeout cycle still completes normally.
        if (bus.mem_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) StallM = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_WAIT && !done && !tmo) ? cnt_q + 8'd1 : 8'd0;
    end
  end

  // M -> W register and bus request register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      PCSrcW        <= 1'b0;
      RegWriteW     <= 1'b0;
      MemtoRegW     <= 1'b0;
      RdW           <= '0;
      ALUOutW       <= '0;
      ReadDataW     <= '0;
      mem_err       <= 1'b0;
    end else begin
      if (start) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= MemWriteM;
        bus.mem_addr  <= {ALUResultM[31:2], 2'b00};
        bus.mem_wdata <= wdata_st;
        bus.mem_be    <= be_st;
      end else if (done || tmo) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
      end

      if (state_q == S_IDLE || done || tmo) begin
        PCSrcW    <= PCSrcM;
        RdW       <= RdM;
        ALUOutW   <= ALUResultM;
        RegWriteW <= RegWriteM;
        MemtoRegW <= MemtoRegM;
        ReadDataW <= '0;
        if (state_q == S_IDLE && access) begin
          RegWriteW <= 1'b0;
          MemtoRegW <= 1'b0;
        end
        if (tmo) RegWriteW <= 1'b0;
        if (done && MemtoRegM)
          ReadDataW <= load_extract(bus.mem_rdata, ALUResultM[1:0], is_word, is_half, ld_signed);
      end

      if (squash || tmo) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one instance with the default timeout and one with TIMEOUT=4.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0]  RdM, byteEnableM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [1:0]  Instr27_26M, Instr6_5M;
  logic        ack;
  logic [31:0] rdata;

  logic        StallM, PCSrcW, RegWriteW, MemtoRegW, mem_err;
  logic [3:0]  RdW;
  logic [31:0] ALUOutW, ReadDataW;
  logic        StallM_b, PCSrcW_b, RegWriteW_b, MemtoRegW_b, mem_err_b;
  logic [3:0]  RdW_b;
  logic [31:0] ALUOutW_b, ReadDataW_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if bus_a ();
  mem_stage_lsu_if bus_b ();
  assign bus_a.mem_ack   = ack;
  assign bus_a.mem_rdata = rdata;
  assign bus_b.mem_ack   = ack;
  assign bus_b.mem_rdata = rdata;

  mem_stage_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .Instr27_26M(Instr27_26M), .Instr6_5M(Instr6_5M), .byteEnableM(byteEnableM),
    .bus(bus_a), .StallM(StallM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .RdW(RdW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
    .mem_err(mem_err)
  );

  mem_stage_lsu #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .reset(reset), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .Instr27_26M(Instr27_26M), .Instr6_5M(Instr6_5M), .byteEnableM(byteEnableM),
    .bus(bus_b), .StallM(StallM_b), .PCSrcW(PCSrcW_b), .RegWriteW(RegWriteW_b),
    .MemtoRegW(MemtoRegW_b), .RdW(RdW_b), .ALUOutW(ALUOutW_b), .ReadDataW(ReadDataW_b),
    .mem_err(mem_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_m(input logic pcs, input logic rw, input logic m2r, input logic mw,
                       input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [1:0] i27, input logic [1:0] i65, input logic [3:0] be);
    PCSrcM = pcs; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    RdM = rd; ALUResultM = alu; WriteDataM = wd;
    Instr27_26M = i27; Instr6_5M = i65; byteEnableM = be;
  endtask

  task automatic nop();
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 2'b00, 2'b00, 4'h0);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    ack = 1'b0;
    rdata = '0;
    edge1();
    reset = 1'b0;
  endtask

  // Called at edge+1 with the M bundle already applied; returns at edge+1 after completion.
  task automatic mem_txn(input string tag, input int delay, input logic [31:0] rd_v,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_be, input logic e_we);
    ack = 1'b0;
    #1;
    chk({tag, "_stall_idle"}, StallM, 1);
    chk({tag, "_req_idle"}, bus_a.mem_req, 0);
    for (int i = 0; i < delay; i++) begin
      edge1();
      chk({tag, "_req"}, bus_a.mem_req, 1);
      chk({tag, "_addr"}, bus_a.mem_addr, e_addr);
      chk({tag, "_we"}, bus_a.mem_we, e_we);
      chk({tag, "_be"}, bus_a.mem_be, e_be);
      chk({tag, "_wdata"}, bus_a.mem_wdata, e_wdata);
      chk({tag, "_stall"}, StallM, 1);
    end
    edge1();
    ack = 1'b1;
    rdata = rd_v;
    #1;
    chk({tag, "_addr_ack"}, bus_a.mem_addr, e_addr);
    chk({tag, "_we_ack"}, bus_a.mem_we, e_we);
    chk({tag, "_be_ack"}, bus_a.mem_be, e_be);
    chk({tag, "_wdata_ack"}, bus_a.mem_wdata, e_wdata);
    chk({tag, "_stall_ack"}, StallM, 0);
    edge1();
    ack = 1'b0;
    chk({tag, "_req_done"}, bus_a.mem_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    nop();
    ack = 1'b0;
    rdata = '0;
    #3;
    chk("rst_stall", StallM, 0);
    chk("rst_req", bus_a.mem_req, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_regw", RegWriteW, 0);
    chk("rst_alu", ALUOutW, 0);
    chk("rst_rdata", ReadDataW, 0);
    chk("rst_addr", bus_a.mem_addr, 0);
    edge1();
    reset = 1'b0;

    // Non-memory instruction passes straight to W; ack while idle is ignored
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0, 2'b01, 2'b00, 4'hF);
    ack = 1'b1;
    #1;
    chk("nop_stall", StallM, 0);
    edge1();
    chk("nop_req", bus_a.mem_req, 0);
    chk("nop_regw", RegWriteW, 1);
    chk("nop_pcs", PCSrcW, 1);
    chk("nop_alu", ALUOutW, 32'h55);
    chk("nop_rd", RdW, 3);
    chk("nop_rdata", ReadDataW, 0);
    ack = 1'b0;

    // Word load, ack on the second WAIT cycle
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h100, 32'h0, 2'b01, 2'b00, 4'hF);
    mem_txn("wld", 1, 32'hDEADBEEF, 32'h100, 32'h0, 4'hF, 1'b0);
    chk("wld_data", ReadDataW, 32'hDEADBEEF);
    chk("wld_regw", RegWriteW, 1);
    chk("wld_m2r", MemtoRegW, 1);
    chk("wld_rd", RdW, 5);
    chk("wld_alu", ALUOutW, 32'h100);
    nop();

    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h203, 32'h0, 2'b00, 2'b10, 4'hF);
    mem_txn("sb", 0, 32'h80112233, 32'h200, 32'h0, 4'hF, 1'b0);
    chk("sb_data", ReadDataW, 32'hFFFFFF80);
    nop();

    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h202, 32'h0, 2'b00, 2'b11, 4'hF);
    mem_txn("sh", 0, 32'h80112233, 32'h200, 32'h0, 4'hF, 1'b0);
    chk("sh_data", ReadDataW, 32'hFFFF8011);
    nop();

    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h202, 32'h0, 2'b00, 2'b01, 4'hF);
    mem_txn("h", 0, 32'h80112233, 32'h200, 32'h0, 4'hF, 1'b0);
    chk("h_data", ReadDataW, 32'h00008011);
    nop();

    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h203, 32'h0, 2'b01, 2'b00, 4'b0001);
    mem_txn("ldrb", 0, 32'h80112233, 32'h200, 32'h0, 4'hF, 1'b0);
    chk("ldrb_data", ReadDataW, 32'h00000080);
    nop();

    set_m(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h301, 32'h000000A5, 2'b01, 2'b00, 4'b0010);
    mem_txn("stb", 0, 32'h0, 32'h300, 32'hA5A5A5A5, 4'b0010, 1'b1);
    chk("stb_regw", RegWriteW, 0);
    chk("stb_rdata", ReadDataW, 0);
    nop();

    set_m(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h302, 32'h1234ABCD, 2'b00, 2'b01, 4'hF);
    mem_txn("sth", 0, 32'h0, 32'h300, 32'hABCDABCD, 4'b1100, 1'b1);
    nop();

    // Ack withheld for 5 WAIT cycles
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 32'h500, 32'h0, 2'b01, 2'b00, 4'hF);
    mem_txn("dly", 5, 32'hCAFEF00D, 32'h500, 32'h0, 4'hF, 1'b0);
    chk("dly_data", ReadDataW, 32'hCAFEF00D);
    chk("dly_rd", RdW, 7);
    nop();

    // Misaligned halfword load is squashed without a bus request
    do_reset();
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 32'h401, 32'h0, 2'b00, 2'b01, 4'hF);
    #1;
    chk("mis_stall", StallM, 0);
    edge1();
    chk("mis_req", bus_a.mem_req, 0);
    chk("mis_err", mem_err, 1);
    chk("mis_regw", RegWriteW, 0);
    chk("mis_m2r", MemtoRegW, 0);
    nop();
    edge1();
    chk("mis_err_sticky", mem_err, 1);

    // Reset while a transaction is outstanding
    do_reset();
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'h700, 32'h0, 2'b01, 2'b00, 4'hF);
    edge1();
    chk("mrst_req_pre", bus_a.mem_req, 1);
    reset = 1'b1;
    #1;
    chk("mrst_req", bus_a.mem_req, 0);
    chk("mrst_stall", StallM, 0);
    chk("mrst_addr", bus_a.mem_addr, 0);
    chk("mrst_be", bus_a.mem_be, 0);
    chk("mrst_regw", RegWriteW, 0);
    nop();
    edge1();
    reset = 1'b0;

    // TIMEOUT=4 instance: no ack at all
    do_reset();
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h600, 32'h0, 2'b01, 2'b00, 4'hF);
    #1;
    chk("to_stall_idle", StallM_b, 1);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("to_stall", StallM_b, 1);
      chk("to_req", bus_b.mem_req, 1);
    end
    edge1();
    chk("to_stall_last", StallM_b, 0);
    chk("to_err_pre", mem_err_b, 0);
    edge1();
    chk("to_err", mem_err_b, 1);
    chk("to_req_drop", bus_b.mem_req, 0);
    chk("to_regw", RegWriteW_b, 0);
    chk("to_rdata", ReadDataW_b, 0);
    chk("to_m2r", MemtoRegW_b, 1);
    chk("to_rd", RdW_b, 9);
    nop();

    // TIMEOUT=4 instance: ack in the 4th WAIT cycle wins over the timeout
    do_reset();
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd10, 32'h604, 32'h0, 2'b01, 2'b00, 4'hF);
    for (int i = 0; i < 3; i++) edge1();
    edge1();
    ack = 1'b1;
    rdata = 32'h13579BDF;
    #1;
    chk("co_stall", StallM_b, 0);
    edge1();
    ack = 1'b0;
    chk("co_err", mem_err_b, 0);
    chk("co_regw", RegWriteW_b, 1);
    chk("co_data", ReadDataW_b, 32'h13579BDF);
    chk("co_req", bus_b.mem_req, 0);
    nop();
    edge1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
